fifo_rd_stream: RTL
===================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits.
REQ-002 SHALL have parameter PKT_LEN, default 4, beats per packet (range 2..256).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port fifo_empty  input  1  upstream FIFO empty flag.
REQ-006 SHALL have port fifo_wr_en  input  1  upstream FIFO write strobe; a write blocks a read that cycle.
REQ-007 SHALL have port fifo_dout  input  WIDTH  upstream FIFO read data.
REQ-008 SHALL have port fifo_rd_en  output  1  read request to upstream FIFO.
REQ-009 SHALL have port m_valid  output  1  downstream beat valid.
REQ-010 SHALL have port m_ready  input  1  downstream ready.
REQ-011 SHALL have port m_data  output  WIDTH  downstream beat data.
REQ-012 SHALL have port m_last  output  1  final beat of a PKT_LEN-beat packet.
REQ-013 SHALL have port pkt_cnt  output  16  completed-packet count, wraps 0xFFFF->0.

Function
REQ-014 SHALL define read grant = fifo_rd_en && !fifo_empty && !fifo_wr_en; only granted reads return data.
REQ-015 SHALL capture fifo_dout into the buffer exactly one cycle after a grant (registered flag inflight = grant delayed one cycle).
REQ-016 SHALL hold a 3-entry in-order buffer; occupancy cnt 0..3.
REQ-017 SHALL drive fifo_rd_en = !fifo_empty && (cnt + inflight) < 3, from registered state only; no combinational path from m_ready.
REQ-018 SHALL drive m_valid = (cnt != 0) and m_data = buffer head.
REQ-019 SHALL pop on m_valid && m_ready; a simultaneous push and pop leaves cnt unchanged and preserves order.
REQ-020 SHALL hold m_data/m_valid stable while m_valid && !m_ready.
REQ-021 SHALL never overflow (push at cnt=3 impossible by REQ-017) and never pop at cnt=0.
REQ-022 SHALL sustain one beat per cycle when FIFO is non-empty, no upstream writes, and m_ready=1, after 2-cycle startup latency (rd_en at t, m_valid at t+2).
REQ-023 SHALL count accepted beats in beat_cnt 0..PKT_LEN-1; wrap to 0 after PKT_LEN-1.
REQ-024 SHALL assert m_last = m_valid && (beat_cnt == PKT_LEN-1).
REQ-025 SHALL increment pkt_cnt on each accepted beat with m_last=1.
REQ-026 SHALL stall output (m_valid=0), not drop state, when FIFO runs empty mid-packet; beat_cnt is retained.

Reset
REQ-027 SHALL, on rst=0, asynchronously clear cnt, inflight, beat_cnt, pkt_cnt, buffer pointers; m_valid=0, m_last=0, fifo_rd_en=0, m_data=0.
REQ-028 SHALL discard any in-flight read data on reset assertion mid-operation; the first beat after release starts a new packet (beat_cnt=0).
REQ-029 SHALL drive fifo_rd_en=0 while rst=0 regardless of fifo_empty.

Structure
REQ-030 SHALL place WIDTH/PKT_LEN defaults and buffer depth constant (3) in shared package fifo_stream_pkg.
REQ-031 SHALL implement the 3-entry buffer as sub-module rd_skid_buf (push, pop, data, cnt); beat/packet counters stay in top.

Verification
REQ-032 SHALL cover streaming: FIFO preloaded 0x01..0x08, m_ready=1 -> rd_en at t, m_valid at t+2, 8 consecutive beats 0x01..0x08, m_last on 0x04 and 0x08, pkt_cnt=2.
REQ-033 SHALL cover backpressure: m_ready=0 for 10 cycles with FIFO holding 6 entries -> cnt saturates at 3, fifo_rd_en=0, m_data held at 0x01; on release order 0x01..0x06 intact.
REQ-034 SHALL cover write collision: fifo_wr_en=1 during a fifo_rd_en cycle -> no capture next cycle, no duplicate/lost beat.
REQ-035 SHALL cover empty mid-packet: 2 bytes then FIFO empty 5 cycles then 2 bytes -> m_last only on 4th beat, pkt_cnt=1.
REQ-036 SHALL cover reset mid-operation: rst=0 with cnt=2, inflight=1 -> outputs zero immediately; after release next beats start at beat_cnt=0, pkt_cnt=0.
REQ-037 SHALL cover pkt_cnt wrap: 65536 packets -> pkt_cnt returns to 0x0000.

Source files
------------

// File: rtl/fifo_stream_pkg.sv
// Shared constants and helpers for the FIFO-to-stream read path.
package fifo_stream_pkg;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_PKT_LEN = 4;
  localparam int unsigned BUF_DEPTH   = 3;

  // Pointer increment modulo the 3-entry buffer depth.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// Three-entry in-order buffer that absorbs FIFO read latency behind the stream.
module rd_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       cnt
);

  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [1:0]       wr_ptr_q;
  logic [1:0]       rd_ptr_q;
  logic [1:0]       cnt_q;
  logic             push_ok;
  logic             pop_ok;

  // Guards: never pop empty, never push into a full buffer unless it drains this cycle.
  always_comb begin
    pop_ok  = pop && (cnt_q != 2'd0);
    push_ok = push && ((cnt_q != 2'(BUF_DEPTH)) || pop_ok);
  end

  // Storage, pointers and occupancy; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_ok) rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign dout = mem_q[rd_ptr_q];
  assign cnt  = cnt_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Reads a synchronous FIFO and presents its data as a valid/ready packet stream.
module fifo_rd_stream
  import fifo_stream_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned PKT_LEN = DEF_PKT_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic             fifo_wr_en,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_rd_en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic [15:0]      pkt_cnt
);

  localparam int unsigned BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  logic              inflight_q;
  logic [1:0]        cnt;
  logic [2:0]        occ;
  logic              grant;
  logic              pop;
  logic [BEAT_W-1:0] beat_cnt_q;
  logic [15:0]       pkt_cnt_q;

  // Read request from registered occupancy only; held low while in reset.
  always_comb begin
    occ        = {1'b0, cnt} + {2'b00, inflight_q};
    fifo_rd_en = rst && !fifo_empty && (occ < 3'(BUF_DEPTH));
    grant      = fifo_rd_en && !fifo_empty && !fifo_wr_en;
    m_valid    = (cnt != 2'd0);
    m_last     = m_valid && (beat_cnt_q == BEAT_W'(PKT_LEN - 1));
    pop        = m_valid && m_ready;
  end

  // A granted read returns data on the following cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) inflight_q <= 1'b0;
    else      inflight_q <= grant;
  end

  rd_skid_buf #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk  (clk),
    .rst  (rst),
    .push (inflight_q),
    .pop  (pop),
    .din  (fifo_dout),
    .dout (m_data),
    .cnt  (cnt)
  );

  // Beat position within the packet and completed-packet count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt_q <= '0;
      pkt_cnt_q  <= 16'd0;
    end else if (pop) begin
      if (m_last) begin
        beat_cnt_q <= '0;
        pkt_cnt_q  <= pkt_cnt_q + 16'd1;
      end else begin
        beat_cnt_q <= beat_cnt_q + 1'b1;
      end
    end
  end

  assign pkt_cnt = pkt_cnt_q;

endmodule
